adder_pipe_seg: RTL and testbench

- Parametrised, handshaked successor to the fixed 64-bit registered adder wrapper.
- Splits a WIDTH-bit add/subtract into STAGES carry-chained segments, one segment per pipeline stage, with operand/result skew registers.
- Sustains one operation per cycle under valid/ready flow control.
- Used as the timing-closure adder for the prefix-adder sweep runs and as a drop-in datapath adder.

---
 rtl/adder_pkg.sv | 31 +++
 rtl/adder_seg.sv | 37 +++
 rtl/adder_pipe_seg.sv | 123 ++++++++++++
 tb/tb_adder_pipe_seg.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg
//   Shared definitions for the segmented / prefix adder wrappers.
//   - default geometry constants used by the wrappers
//   - seg_width() / split_ok() helpers for segment sizing and legality
//   - stage_ctl_t: per-pipeline-stage valid bit plus the carry handed on
//     to the next segment
package adder_pkg;

  localparam int ADDER_DEFAULT_WIDTH      = 64;
  localparam int ADDER_DEFAULT_STAGES     = 4;
  localparam bit ADDER_DEFAULT_SIGNED_OVF = 1'b1;

  // Operation select encoding shared by all adder wrappers
  localparam logic ADDER_OP_ADD = 1'b0;
  localparam logic ADDER_OP_SUB = 1'b1;

  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  function automatic int seg_width(input int width, input int stages);
    return (stages > 0) ? (width / stages) : 0;
  endfunction

  // A split is legal when every stage gets the same non-zero segment width
  function automatic bit split_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_seg.sv
// adder_seg
//   Combinational SEG-bit adder slice with carry-in. This is the only
//   place the actual addition happens, so the body can be replaced by a
//   prefix structure without touching the pipeline around it.
// Ports:
//   a, b     in  SEG  operand slices (b already inverted for subtraction)
//   cin      in  1    carry into bit 0 of the slice
//   sum      out SEG  slice sum
//   cout     out 1    carry out of the slice MSB
//   msb_cin  out 1    carry into the slice MSB (for signed overflow)
module adder_seg
  import adder_pkg::*;
#(
  parameter int SEG = 16
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           msb_cin
);

  logic [SEG:0] total;

  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
  end

  assign sum  = total[SEG-1:0];
  assign cout = total[SEG];

  // The sum bit is a ^ b ^ carry_in, so the carry into the MSB falls out
  // of the MSB sum bit; for SEG=1 this is simply cin.
  assign msb_cin = a[SEG-1] ^ b[SEG-1] ^ total[SEG-1];

endmodule

// File: rtl/adder_pipe_seg.sv
// adder_pipe_seg
//   Pipelined WIDTH-bit add/subtract split into STAGES carry-chained
//   segments, one segment per stage, under valid/ready flow control with
//   a global stall. Upper operand segments ride along in skew registers
//   and finished lower sum segments ride along in de-skew registers so a
//   whole result leaves at once, STAGES cycles after capture.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake
//   a, b                 WIDTH-bit operands
//   cin                  carry-in (ignored when sub=1)
//   sub                  1 = a - b, 0 = a + b + cin
//   out_valid/out_ready  result handshake
//   sum                  result modulo 2^WIDTH
//   cout                 carry out of MSB (for sub: 1 = no borrow)
//   ovf                  two's-complement overflow (0 if SIGNED_OVF=0)
module adder_pipe_seg
  import adder_pkg::*;
#(
  parameter int WIDTH      = ADDER_DEFAULT_WIDTH,
  parameter int STAGES     = ADDER_DEFAULT_STAGES,
  parameter bit SIGNED_OVF = ADDER_DEFAULT_SIGNED_OVF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
    $error("adder_pipe_seg: WIDTH=%0d is not an even split into STAGES=%0d (need 1 <= STAGES <= WIDTH)",
           WIDTH, STAGES);
  end

  // Bank k holds the beat that stage k is working on
  logic [WIDTH-1:0] a_r    [STAGES];
  logic [WIDTH-1:0] b_r    [STAGES];
  logic [WIDTH-1:0] part_r [STAGES];
  stage_ctl_t       ctl_r  [STAGES];

  logic [SEG-1:0]   seg_sum     [STAGES];
  logic             seg_cout    [STAGES];
  logic             seg_msb_cin [STAGES];
  logic [WIDTH-1:0] part_next   [STAGES];

  logic stall;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    adder_seg #(.SEG(SEG)) u_seg (
      .a       (a_r[k][k*SEG +: SEG]),
      .b       (b_r[k][k*SEG +: SEG]),
      .cin     (ctl_r[k].carry),
      .sum     (seg_sum[k]),
      .cout    (seg_cout[k]),
      .msb_cin (seg_msb_cin[k])
    );
  end

  // Drop each stage's freshly computed segment into its partial sum
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      part_next[k] = part_r[k];
      part_next[k][k*SEG +: SEG] = seg_sum[k];
    end
  end

  // Operand skew and partial-sum de-skew registers; contents of empty
  // stages are don't-care, so no reset here
  always_ff @(posedge clk) begin
    if (!stall) begin
      a_r[0]    <= a;
      b_r[0]    <= sub ? ~b : b;
      part_r[0] <= '0;
      for (int k = 1; k < STAGES; k++) begin
        a_r[k]    <= a_r[k-1];
        b_r[k]    <= b_r[k-1];
        part_r[k] <= part_next[k-1];
      end
    end
  end

  // Stage valid/carry chain and the output stage. Outputs only load when
  // a real beat leaves the last stage so they hold across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        ctl_r[k].valid <= 1'b0;
      end
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (!stall) begin
      ctl_r[0].valid <= in_valid;
      ctl_r[0].carry <= sub | cin;
      for (int k = 1; k < STAGES; k++) begin
        ctl_r[k].valid <= ctl_r[k-1].valid;
        ctl_r[k].carry <= seg_cout[k-1];
      end
      out_valid <= ctl_r[STAGES-1].valid;
      if (ctl_r[STAGES-1].valid) begin
        sum  <= part_next[STAGES-1];
        cout <= seg_cout[STAGES-1];
        ovf  <= SIGNED_OVF ? (seg_cout[STAGES-1] ^ seg_msb_cin[STAGES-1]) : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder_pipe_seg.sv
// tb_adder_pipe_seg
//   Self-checking bench: four DUT lanes with different WIDTH/STAGES share
//   one clock. Lane 0 (64/4) runs directed scenarios with literal checks;
//   lanes 1..3 run long random streams with random backpressure. Every
//   lane has a scoreboard fed by an arithmetic reference model.
module tb_adder_pipe_seg;

  localparam int NL    = 4;
  localparam int BEATS = 10000;

  function automatic int lane_width(input int g);
    case (g)
      0, 1:    return 64;
      2:       return 32;
      default: return 16;
    endcase
  endfunction

  function automatic int lane_stages(input int g);
    case (g)
      0:       return 4;
      1:       return 1;
      2:       return 8;
      default: return 16;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [NL];
  logic        in_valid  [NL];
  logic        in_ready  [NL];
  logic [63:0] a         [NL];
  logic [63:0] b         [NL];
  logic        cin       [NL];
  logic        sub       [NL];
  logic        out_valid [NL];
  logic        out_ready [NL];
  logic [63:0] sum       [NL];
  logic        cout      [NL];
  logic        ovf       [NL];

  int pending [NL];
  bit done    [NL];
  int n_cmp  = 0;
  int n_fail = 0;

  // Reference: exact integer arithmetic in 128 bits, then reduce to w bits
  function automatic logic [65:0] ref_model(input int w, input logic [63:0] a_in,
                                            input logic [63:0] b_in, input logic cin_in,
                                            input logic sub_in);
    logic [127:0] top, mask, ua, ub, us;
    logic signed [127:0] sa, sb, ss, hi, lo;
    logic c, v;
    top  = 128'd1 << w;
    mask = top - 128'd1;
    ua   = {64'd0, a_in} & mask;
    ub   = {64'd0, b_in} & mask;
    sa   = (ua >= (top >> 1)) ? $signed(ua - top) : $signed(ua);
    sb   = (ub >= (top >> 1)) ? $signed(ub - top) : $signed(ub);
    hi   = $signed((top >> 1) - 128'd1);
    lo   = -$signed(top >> 1);
    if (sub_in) begin
      us = ua - ub;
      ss = sa - sb;
      c  = (ua >= ub);
    end else begin
      us = ua + ub + {127'd0, cin_in};
      ss = sa + sb + $signed({127'd0, cin_in});
      c  = (us >= top);
    end
    v  = (ss > hi) || (ss < lo);
    us = us & mask;
    return {v, c, us[63:0]};
  endfunction

  function automatic logic [63:0] rand_operand(input int w);
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'd1 << (w - 1);
      3:       return (64'd1 << (w - 1)) - 64'd1;
      4:       return 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [71:0] actual,
                             input logic [71:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Present one beat and hold it until accepted; leaves in_valid high so
  // the caller can chain beats back to back
  task automatic applyStimulus(input int ln, input logic [63:0] av, input logic [63:0] bv,
                               input logic cv, input logic sv);
    bit acc;
    int waited;
    a[ln] = av; b[ln] = bv; cin[ln] = cv; sub[ln] = sv; in_valid[ln] = 1'b1;
    acc = 1'b0;
    waited = 0;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = in_ready[ln];
      @(posedge clk);
      #1;
      waited++;
    end
    checkOutput($sformatf("lane%0d_accept", ln), {71'd0, acc}, 72'd1);
  endtask

  task automatic waitValid(input int ln, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!out_valid[ln] && cycles < 200);
    checkOutput($sformatf("lane%0d_valid_seen", ln), {71'd0, out_valid[ln]}, 72'd1);
  endtask

  for (genvar g = 0; g < NL; g++) begin : lane
    localparam int W = lane_width(g);
    localparam int S = lane_stages(g);
    logic [W-1:0] sum_w;
    logic [65:0]  exp_q [$];
    logic         hold_v = 1'b0;
    logic [65:0]  hold_val;

    adder_pipe_seg #(.WIDTH(W), .STAGES(S), .SIGNED_OVF(1'b1)) dut (
      .clk       (clk),
      .rst       (rst[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .a         (a[g][W-1:0]),
      .b         (b[g][W-1:0]),
      .cin       (cin[g]),
      .sub       (sub[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .sum       (sum_w),
      .cout      (cout[g]),
      .ovf       (ovf[g])
    );
    assign sum[g] = 64'(sum_w);

    // Scoreboard: decide at the negedge what the coming edge will transfer
    always @(negedge clk) begin
      logic [65:0] act;
      act = {ovf[g], cout[g], sum[g]};
      if (rst[g]) begin
        exp_q.delete();
        hold_v = 1'b0;
      end else begin
        checkOutput($sformatf("lane%0d_in_ready", g), {71'd0, in_ready[g]},
                    {71'd0, !(out_valid[g] && !out_ready[g])});
        if (hold_v) begin
          checkOutput($sformatf("lane%0d_stall_valid", g), {71'd0, out_valid[g]}, 72'd1);
          checkOutput($sformatf("lane%0d_stall_hold", g), {6'd0, act}, {6'd0, hold_val});
        end
        hold_v   = out_valid[g] && !out_ready[g];
        hold_val = act;
        if (out_valid[g] && out_ready[g]) begin
          checkOutput($sformatf("lane%0d_result_expected", g),
                      {71'd0, exp_q.size() != 0}, 72'd1);
          if (exp_q.size() != 0)
            checkOutput($sformatf("lane%0d_result", g), {6'd0, act}, {6'd0, exp_q.pop_front()});
        end
        if (in_valid[g] && in_ready[g])
          exp_q.push_back(ref_model(W, a[g], b[g], cin[g], sub[g]));
      end
      pending[g] = exp_q.size();
    end
  end

  // Random streams with random backpressure on the parameter-sweep lanes
  for (genvar g = 1; g < NL; g++) begin : rnd
    localparam int W = lane_width(g);
    localparam int S = lane_stages(g);
    initial begin
      int sent;
      int lat;
      bit acc;
      rst[g] = 1'b1; in_valid[g] = 1'b0; a[g] = '0; b[g] = '0;
      cin[g] = 1'b0; sub[g] = 1'b0; out_ready[g] = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst[g] = 1'b0;
      applyStimulus(g, rand_operand(W), rand_operand(W), 1'($urandom), 1'($urandom));
      in_valid[g] = 1'b0;
      waitValid(g, lat);
      checkOutput($sformatf("lane%0d_latency", g), 72'(lat), 72'(S));
      sent = 0;
      while (sent < BEATS) begin
        @(negedge clk);
        acc = in_valid[g] && in_ready[g];
        @(posedge clk);
        #1;
        if (acc) sent++;
        if (!in_valid[g] || acc) begin
          in_valid[g] = (sent < BEATS) && ($urandom_range(0, 3) != 0);
          a[g]   = rand_operand(W);
          b[g]   = rand_operand(W);
          cin[g] = 1'($urandom);
          sub[g] = 1'($urandom);
        end
        out_ready[g] = ($urandom_range(0, 3) != 0);
      end
      in_valid[g]  = 1'b0;
      out_ready[g] = 1'b1;
      repeat (S + 4) @(posedge clk);
      done[g] = 1'b1;
    end
  end

  // Directed scenarios on lane 0 (WIDTH=64, STAGES=4)
  initial begin : directed
    int lat;
    rst[0] = 1'b1; in_valid[0] = 1'b0; a[0] = '0; b[0] = '0;
    cin[0] = 1'b0; sub[0] = 1'b0; out_ready[0] = 1'b1;

    checkOutput("model_ripple", {6'd0, ref_model(64, '1, 64'd1, 1'b0, 1'b0)}, {8'd0, 64'd0} | 72'h01_0000000000000000);
    checkOutput("model_sub_neg", {6'd0, ref_model(64, 64'd3, 64'd5, 1'b0, 1'b1)}, {8'd0, 64'hFFFF_FFFF_FFFF_FFFE});
    checkOutput("model_sub_ovf", {6'd0, ref_model(64, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1)},
                {8'h03, 64'h7FFF_FFFF_FFFF_FFFF});
    checkOutput("model_w16_ovf", {6'd0, ref_model(16, 64'h7FFF, 64'd0, 1'b1, 1'b0)}, {8'h02, 64'h8000});

    repeat (3) @(posedge clk);
    #1 rst[0] = 1'b0;
    @(negedge clk);
    checkOutput("reset_out_valid", {71'd0, out_valid[0]}, 72'd0);
    checkOutput("reset_outputs", {6'd0, ovf[0], cout[0], sum[0]}, 72'd0);
    checkOutput("reset_in_ready", {71'd0, in_ready[0]}, 72'd1);
    @(posedge clk);
    #1;

    // Full carry ripple through all four segments
    applyStimulus(0, '1, 64'd1, 1'b0, 1'b0);
    in_valid[0] = 1'b0;
    waitValid(0, lat);
    checkOutput("ripple_latency", 72'(lat), 72'd4);
    checkOutput("ripple_result", {6'd0, ovf[0], cout[0], sum[0]}, {8'h01, 64'd0});

    // Three back-to-back subtractions
    applyStimulus(0, 64'd5, 64'd3, 1'b0, 1'b1);
    applyStimulus(0, 64'd3, 64'd5, 1'b0, 1'b1);
    applyStimulus(0, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
    in_valid[0] = 1'b0;
    waitValid(0, lat);
    checkOutput("sub0_result", {5'd0, out_valid[0], ovf[0], cout[0], sum[0]}, {8'h05, 64'd2});
    @(posedge clk);
    #1;
    checkOutput("sub1_result", {5'd0, out_valid[0], ovf[0], cout[0], sum[0]},
                {8'h04, 64'hFFFF_FFFF_FFFF_FFFE});
    @(posedge clk);
    #1;
    checkOutput("sub2_result", {5'd0, out_valid[0], ovf[0], cout[0], sum[0]},
                {8'h07, 64'h7FFF_FFFF_FFFF_FFFF});

    // Carry-in pushing into signed overflow
    applyStimulus(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
    in_valid[0] = 1'b0;
    waitValid(0, lat);
    checkOutput("cin_ovf_result", {6'd0, ovf[0], cout[0], sum[0]},
                {8'h02, 64'h8000_0000_0000_0000});
    repeat (6) @(posedge clk);
    #1;

    // Eight random beats with a five-cycle output stall mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++)
          applyStimulus(0, rand_operand(64), rand_operand(64), 1'($urandom), 1'($urandom));
        in_valid[0] = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          checkOutput("stall_in_ready_low", {71'd0, in_ready[0]}, 72'd0);
          checkOutput("stall_out_valid_high", {71'd0, out_valid[0]}, 72'd1);
          @(posedge clk);
          #1;
        end
        out_ready[0] = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    checkOutput("backpressure_drained", 72'(pending[0]), 72'd0);

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++)
      applyStimulus(0, rand_operand(64), rand_operand(64), 1'($urandom), 1'($urandom));
    in_valid[0] = 1'b0;
    rst[0] = 1'b1;
    @(posedge clk);
    #1 rst[0] = 1'b0;
    @(negedge clk);
    checkOutput("flush_out_valid", {71'd0, out_valid[0]}, 72'd0);
    checkOutput("flush_sum", {8'd0, sum[0]}, 72'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      checkOutput("flush_no_result", {71'd0, out_valid[0]}, 72'd0);
    end
    applyStimulus(0, 64'd10, 64'd20, 1'b0, 1'b0);
    in_valid[0] = 1'b0;
    waitValid(0, lat);
    checkOutput("post_flush_result", {6'd0, ovf[0], cout[0], sum[0]}, {8'd0, 64'd30});
    repeat (8) @(posedge clk);
    done[0] = 1'b1;
  end

  initial begin : finisher
    wait (done[0] && done[1] && done[2] && done[3]);
    @(negedge clk);
    for (int i = 0; i < NL; i++)
      checkOutput($sformatf("lane%0d_drained", i), 72'(pending[i]), 72'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
